// File: rtl/prbs_gen_multi.sv
// Run-time selectable PRBS7/15/23/31 word generator with valid/ready output,
// seed/mode load and accepted-word counter. Optional macro PRBS_ERR_INJECT_EN.
module prbs_gen_multi #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [30:0]      seed,
  input  logic             err_inject,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       mode_q,
  output logic [CNT_W-1:0] word_cnt
);

  function automatic logic [30:0] mode_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_7FFF;
      2'd2:    return 31'h007F_FFFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic lfsr_tap(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[6]  ^ s[5];
      2'd1:    return s[14] ^ s[13];
      2'd2:    return s[22] ^ s[17];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  logic [30:0]      lfsr_q, lfsr_d;
  logic [1:0]       mode_sel_q, mode_sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [30:0]      lfsr_walk;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_inj;
  logic [30:0]      seed_masked;
  logic [30:0]      lfsr_load;
  logic             advance;
  logic             accept;

  // Unroll WIDTH Fibonacci steps; the first bit generated lands in the MSB.
  always_comb begin
    logic fb;
    fb        = 1'b0;
    lfsr_walk = lfsr_q;
    word      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      fb                 = lfsr_tap(lfsr_walk, mode_sel_q);
      word[WIDTH-1-k]    = fb;
      lfsr_walk          = {lfsr_walk[29:0], fb} & mode_mask(mode_sel_q);
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // Only the emitted word is corrupted; lfsr_walk is untouched.
  always_comb begin
    word_inj    = word;
    word_inj[0] = word[0] ^ err_inject;
  end
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign word_inj          = word;
`endif

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_masked = seed & mode_mask(mode);
  assign lfsr_load   = (seed_masked == '0) ? 31'd1 : seed_masked;

  assign accept  = valid_q & out_ready;
  assign advance = en & (~valid_q | out_ready);

  always_comb begin
    lfsr_d     = lfsr_q;
    mode_sel_d = mode_sel_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (load) begin
      lfsr_d     = lfsr_load;
      mode_sel_d = mode;
      valid_d    = 1'b0;
      cnt_d      = '0;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (advance) begin
        lfsr_d  = lfsr_walk;
        data_d  = word_inj;
        valid_d = 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= 31'd1;
      mode_sel_q <= 2'(DEFAULT_MODE);
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      mode_sel_q <= mode_sel_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign mode_q    = mode_sel_q;
  assign word_cnt  = cnt_q;

endmodule
